// File: rtl/tc_multi_pkg.sv
// rtl/tc_multi_pkg.sv - shared register offsets, CTRL fields, mode codes and channel state enum
package tc_multi_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_IM    = 3;
  localparam int CTRL_PRESC = 8;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;
  localparam logic [1:0] MODE_FREE    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  // Code 11 is not a mode of its own; it behaves as one-shot.
  function automatic logic mode_oneshot(input logic [1:0] mode);
    return (mode == MODE_ONESHOT) || (mode == 2'b11);
  endfunction

endpackage

// File: rtl/tc_multi_if.sv
// rtl/tc_multi_if.sv - bridge-side register bus of the multi-channel timer
interface tc_multi_if;
  logic [3:0]  byteen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        IRQ;

  modport master (output byteen, addr, wdata, input rdata, IRQ);
  modport slave  (input byteen, addr, wdata, output rdata, IRQ);
endinterface

// File: rtl/tc_channel.sv
// rtl/tc_channel.sv - one timer channel: registers, prescaler, count FSM, pending flag
module tc_channel
  import tc_multi_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] bmask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t             state, state_nx;
  logic               en, im, pend;
  logic [1:0]         mode;
  logic [PRE_W-1:0]   presc, pre_cnt;
  logic [CNT_W-1:0]   preset, count;
  logic               tick, do_load, do_count, set_pend, clr_en;
  logic               wr_ctrl, wr_preset, clr_pend;
  logic [31:0]        ctrl_word, ctrl_base, ctrl_new, preset_new;
  logic               unused_bits;

  // PRESC is compared live, so a new divider applies on the very next cycle
  assign tick = (pre_cnt == presc);
  assign irq  = pend & im;
  assign unused_bits = ^{ctrl_new, preset_new};

  // Bus view of the registers; unimplemented bits read as zero
  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN]           = en;
    ctrl_word[CTRL_MODE +: 2]    = mode;
    ctrl_word[CTRL_IM]           = im;
    ctrl_word[CTRL_PRESC +: PRE_W] = presc;
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata = ctrl_word;
      REG_PRESET: rdata = 32'(preset);
      REG_COUNT:  rdata = 32'(count);
      REG_STATUS: rdata[0] = pend;
    endcase
  end

  // Channel FSM next state and the strobes it issues to the datapath
  always_comb begin
    state_nx = state;
    do_load  = 1'b0;
    do_count = 1'b0;
    set_pend = 1'b0;
    clr_en   = 1'b0;
    case (state)
      ST_IDLE: if (en) state_nx = ST_LOAD;
      ST_LOAD: begin
        do_load  = 1'b1;
        state_nx = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nx = ST_IDLE;
        end else begin
          do_count = 1'b1;
          if (tick && (count <= CNT_W'(1))) state_nx = ST_INT;
        end
      end
      ST_INT: begin
        set_pend = (mode != MODE_FREE);
        if (mode_oneshot(mode)) begin
          clr_en   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_LOAD;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Byte-lane merge; the hardware EN clear is folded in first so a CPU write to byte 0 overrides it
  always_comb begin
    wr_ctrl   = we && (reg_sel == REG_CTRL);
    wr_preset = we && (reg_sel == REG_PRESET);
    clr_pend  = we && (reg_sel == REG_STATUS) && bmask[0] && wdata[0];
    ctrl_base = ctrl_word;
    if (clr_en) ctrl_base[CTRL_EN] = 1'b0;
    ctrl_new   = (ctrl_base & ~bmask) | (wdata & bmask);
    preset_new = (32'(preset) & ~bmask) | (wdata & bmask);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Channel registers, prescaler and counter
  always_ff @(posedge clk) begin
    if (!RESET) begin
      en      <= 1'b0;
      mode    <= '0;
      im      <= 1'b0;
      presc   <= '0;
      preset  <= '0;
      count   <= '0;
      pre_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en    <= ctrl_new[CTRL_EN];
        mode  <= ctrl_new[CTRL_MODE +: 2];
        im    <= ctrl_new[CTRL_IM];
        presc <= ctrl_new[CTRL_PRESC +: PRE_W];
      end else if (clr_en) begin
        en <= 1'b0;
      end
      if (wr_preset) preset <= preset_new[CNT_W-1:0];
      if (do_load) begin
        count   <= preset;
        pre_cnt <= '0;
      end else if (do_count) begin
        if (tick) begin
          pre_cnt <= '0;
          count   <= (count > CNT_W'(1)) ? count - CNT_W'(1) : '0;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
      if (set_pend)      pend <= 1'b1;
      else if (clr_pend) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/tc_multi.sv
// rtl/tc_multi.sv - multi-channel down-counting timer behind one bridge slot
module tc_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8
) (
  input  logic   clk,
  input  logic   RESET,
  tc_multi_if.slave bus
);

  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [31:0] bmask;
  logic        wr_any;
  logic [31:0] ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;
  logic        unused_bits;

  assign ch_sel  = bus.addr[6:4];
  assign reg_sel = bus.addr[3:2];
  assign wr_any  = |bus.byteen;
  assign bmask   = {{8{bus.byteen[3]}}, {8{bus.byteen[2]}}, {8{bus.byteen[1]}}, {8{bus.byteen[0]}}};
  assign unused_bits = ^{bus.addr[31:7], bus.addr[1:0]};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tc_channel #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W)
    ) u_ch (
      .clk    (clk),
      .RESET  (RESET),
      .we     (wr_any && (ch_sel == 3'(g))),
      .reg_sel(reg_sel),
      .bmask  (bmask),
      .wdata  (bus.wdata),
      .rdata  (ch_rdata[g]),
      .irq    (ch_irq[g])
    );
  end

  // Read mux; a channel index with no instance reads as zero
  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) bus.rdata = ch_rdata[i];
    end
  end

  assign bus.IRQ = |ch_irq;

endmodule
